// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light monitor.
package traffic_light_pkg;

    // Decoded signal phase, encoded as reported on o_phase
    typedef enum logic [1:0] {
        PH_NSG = 2'd0,
        PH_NSY = 2'd1,
        PH_EWG = 2'd2,
        PH_EWY = 2'd3
    } phase_e;

    // Lamp order: [5] ns_g, [4] ns_y, [3] ns_r, [2] ew_g, [1] ew_y, [0] ew_r
    localparam logic [5:0] PAT_NSG = 6'b100001;
    localparam logic [5:0] PAT_NSY = 6'b010001;
    localparam logic [5:0] PAT_EWG = 6'b001100;
    localparam logic [5:0] PAT_EWY = 6'b001010;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Legal successor; the cycle order matches the phase encoding
    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(2'(p + 2'd1));
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational lamp-pattern to phase decoder.
module traffic_light_decode
    import traffic_light_pkg::*;
(
    input  logic [5:0] light,
    output phase_e     phase,
    output logic       legal
);

    // Only the four exact patterns are legal; anything else reports phase 0
    always_comb begin
        phase = PH_NSG;
        legal = 1'b1;
        case (light)
            PAT_NSG: phase = PH_NSG;
            PAT_NSY: phase = PH_NSY;
            PAT_EWG: phase = PH_EWG;
            PAT_EWY: phase = PH_EWY;
            default: begin
                phase = PH_NSG;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: decodes lamp patterns, checks phase order
// and dwell, locks onto a clean sequence and counts errors and full cycles.
// Optional feature: define TLM_CONFLICT_EN to enable the sticky
// cross-direction conflict flag on o_conflict.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned MAX_DWELL = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_light,
    input  logic             i_clr,
    output logic [1:0]       o_phase,
    output logic             o_phase_vld,
    output logic             o_lock,
    output logic             o_err,
    output logic             o_err_sticky,
    output logic             o_conflict,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int unsigned TC_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int unsigned DW_W = $clog2(MAX_DWELL + 2);

    phase_e           dec_phase;
    logic             dec_legal;
    phase_e           prev_phase;
    state_e           state;
    state_e           state_nxt;
    logic [TC_W-1:0]  tcnt;
    logic [TC_W-1:0]  tcnt_nxt;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_nxt;
    logic [31:0]      dwell_inc;
    logic             same_c;
    logic             succ_c;
    logic             stuck_c;
    logic             seq_err_c;
    logic             err_evt_c;
    logic             cycle_inc_c;
    logic [CNT_W-1:0] err_base;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] cycle_cnt_nxt;
    logic             sticky_nxt;

    traffic_light_decode u_decode (
        .light (i_light),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // Outside HUNT the previous sample was always legal, so o_phase is its phase
    assign prev_phase = phase_e'(o_phase);

    // Classify the current sample against the previous phase
    always_comb begin
        same_c    = (state != ST_HUNT) && dec_legal && (dec_phase == prev_phase);
        succ_c    = (state != ST_HUNT) && dec_legal && (dec_phase == next_phase(prev_phase));
        dwell_inc = 32'(dwell) + 32'd1;
        stuck_c   = same_c && (dwell_inc > MAX_DWELL);
        seq_err_c = (state != ST_HUNT) && dec_legal && !same_c && !succ_c;
        err_evt_c = !dec_legal || seq_err_c || stuck_c;
    end

    // Next state, transition count and dwell count
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        dwell_nxt = DW_W'(1);
        if (!dec_legal) begin
            dwell_nxt = '0;
        end else if (same_c && !stuck_c) begin
            dwell_nxt = DW_W'(dwell_inc);
        end
        case (state)
            ST_HUNT: begin
                if (dec_legal) begin
                    state_nxt = ST_TRACK;
                    tcnt_nxt  = '0;
                end
            end
            ST_TRACK: begin
                if (err_evt_c) begin
                    state_nxt = dec_legal ? ST_TRACK : ST_HUNT;
                    tcnt_nxt  = '0;
                end else if (succ_c) begin
                    tcnt_nxt = TC_W'(32'(tcnt) + 32'd1);
                    if ((32'(tcnt) + 32'd1) >= LOCK_CNT) begin
                        state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_evt_c) begin
                    state_nxt = dec_legal ? ST_TRACK : ST_HUNT;
                    tcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
                tcnt_nxt  = '0;
            end
        endcase
    end

    // Counter and sticky updates; a coincident clear is applied before the error
    always_comb begin
        cycle_inc_c   = (state_nxt == ST_LOCKED) && succ_c && (dec_phase == PH_NSG);
        err_base      = i_clr ? '0 : o_err_cnt;
        err_cnt_nxt   = err_base;
        if (err_evt_c && (err_base != '1)) begin
            err_cnt_nxt = err_base + CNT_W'(1);
        end
        cycle_cnt_nxt = (i_clr ? '0 : o_cycle_cnt) + CNT_W'(cycle_inc_c);
        sticky_nxt    = (!i_clr && o_err_sticky) || err_evt_c;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Tracking counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tcnt         <= '0;
            dwell        <= '0;
            o_phase      <= 2'd0;
            o_phase_vld  <= 1'b0;
            o_lock       <= 1'b0;
            o_err        <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_cnt    <= '0;
            o_cycle_cnt  <= '0;
        end else begin
            tcnt         <= tcnt_nxt;
            dwell        <= dwell_nxt;
            o_phase      <= dec_phase;
            o_phase_vld  <= dec_legal;
            o_lock       <= (state_nxt == ST_LOCKED);
            o_err        <= err_evt_c;
            o_err_sticky <= sticky_nxt;
            o_err_cnt    <= err_cnt_nxt;
            o_cycle_cnt  <= cycle_cnt_nxt;
        end
    end

`ifdef TLM_CONFLICT_EN
    logic conflict_c;

    // Any NS green/yellow lit together with any EW green/yellow
    assign conflict_c = (|i_light[5:4]) && (|i_light[2:1]);

    // Sticky conflict flag; such samples are already illegal, so one error event
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_conflict <= 1'b0;
        end else begin
            o_conflict <= (!i_clr && o_conflict) || conflict_c;
        end
    end
`else
    assign o_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default parameters).
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [5:0] light;
    logic [1:0] phase;
    logic       phase_vld;
    logic       lock;
    logic       err;
    logic       err_sticky;
    logic       conflict;
    logic [7:0] err_cnt;
    logic [7:0] cycle_cnt;

    int n_run  = 0;
    int n_fail = 0;

    logic [5:0] seq [4] = '{PAT_NSG, PAT_NSY, PAT_EWG, PAT_EWY};

    traffic_light_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_light      (light),
        .i_clr        (clr),
        .o_phase      (phase),
        .o_phase_vld  (phase_vld),
        .o_lock       (lock),
        .o_err        (err),
        .o_err_sticky (err_sticky),
        .o_conflict   (conflict),
        .o_err_cnt    (err_cnt),
        .o_cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample, let it be captured, then settle just after the edge
    task automatic step(input logic [5:0] l, input logic c);
        light = l;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},     32'(phase),      32'd0);
        check({tag, "_vld"},       32'(phase_vld),  32'd0);
        check({tag, "_lock"},      32'(lock),       32'd0);
        check({tag, "_err"},       32'(err),        32'd0);
        check({tag, "_sticky"},    32'(err_sticky), 32'd0);
        check({tag, "_conflict"},  32'(conflict),   32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt),    32'd0);
        check({tag, "_cycle_cnt"}, 32'(cycle_cnt),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        light = PAT_NSG;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Clean sequence: lock on the 5th sample, cycles counted at samples 5 and 9
        for (int k = 0; k < 12; k++) begin
            step(seq[k % 4], 1'b0);
            check("seq_lock",  32'(lock),      32'(k >= 4));
            check("seq_err",   32'(err),       32'd0);
            check("seq_phase", 32'(phase),     32'(k % 4));
            check("seq_vld",   32'(phase_vld), 32'd1);
        end
        check("seq_cycle_cnt", 32'(cycle_cnt), 32'd2);
        check("seq_err_cnt",   32'(err_cnt),   32'd0);

        // Single all-dark sample while locked, then relock after 4 transitions
        step(6'b000000, 1'b0);
        check("dark_err",     32'(err),        32'd1);
        check("dark_lock",    32'(lock),       32'd0);
        check("dark_vld",     32'(phase_vld),  32'd0);
        check("dark_phase",   32'(phase),      32'd0);
        check("dark_err_cnt", 32'(err_cnt),    32'd1);
        check("dark_sticky",  32'(err_sticky), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(seq[k], 1'b0);
            check("relock_wait", 32'(lock), 32'd0);
            check("relock_err",  32'(err),  32'd0);
        end
        step(PAT_NSG, 1'b0);
        check("relock_lock",      32'(lock),      32'd1);
        check("relock_cycle_cnt", 32'(cycle_cnt), 32'd3);

        // Clear with a legal successor, then skip NSY
        step(PAT_NSY, 1'b1);
        check("clr_err_cnt",   32'(err_cnt),    32'd0);
        check("clr_sticky",    32'(err_sticky), 32'd0);
        check("clr_cycle_cnt", 32'(cycle_cnt),  32'd0);
        check("clr_lock",      32'(lock),       32'd1);
        step(PAT_EWG, 1'b0);
        step(PAT_EWY, 1'b0);
        step(PAT_NSG, 1'b0);
        check("skip_pre_cycle", 32'(cycle_cnt), 32'd1);
        step(PAT_EWG, 1'b0);
        check("skip_err",     32'(err),       32'd1);
        check("skip_err_cnt", 32'(err_cnt),   32'd1);
        check("skip_lock",    32'(lock),      32'd0);
        check("skip_vld",     32'(phase_vld), 32'd1);
        check("skip_phase",   32'(phase),     32'd2);
        step(PAT_EWY, 1'b0);
        step(PAT_NSG, 1'b0);
        step(PAT_NSY, 1'b0);
        check("skip_track3", 32'(lock), 32'd0);
        step(PAT_EWG, 1'b0);
        check("skip_relock",    32'(lock),      32'd1);
        check("skip_cycle_cnt", 32'(cycle_cnt), 32'd1);

        // Dwell: NSG held three samples with MAX_DWELL = 1
        step(PAT_EWY, 1'b1);
        check("dwell_clr", 32'(err_cnt), 32'd0);
        step(PAT_NSG, 1'b0);
        check("dwell_1_err",   32'(err),       32'd0);
        check("dwell_1_lock",  32'(lock),      32'd1);
        check("dwell_1_cycle", 32'(cycle_cnt), 32'd1);
        step(PAT_NSG, 1'b0);
        check("dwell_2_err",  32'(err),  32'd1);
        check("dwell_2_lock", 32'(lock), 32'd0);
        step(PAT_NSG, 1'b0);
        check("dwell_3_err",     32'(err),     32'd1);
        check("dwell_3_err_cnt", 32'(err_cnt), 32'd2);

        // Saturation of the error counter under persistent illegal input
        step(6'b111111, 1'b0);
        check("sat_first", 32'(err_cnt), 32'd3);
        for (int k = 1; k < 300; k++) begin
            step(6'b111111, 1'b0);
        end
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_err",     32'(err),     32'd1);
        check("sat_vld",     32'(phase_vld), 32'd0);
        step(6'b111111, 1'b1);
        check("clr_err_err_cnt", 32'(err_cnt),    32'd1);
        check("clr_err_sticky",  32'(err_sticky), 32'd1);
        check("clr_err_cycle",   32'(cycle_cnt),  32'd0);
        step(PAT_NSG, 1'b1);
        check("clr_ok_err_cnt", 32'(err_cnt),    32'd0);
        check("clr_ok_sticky",  32'(err_sticky), 32'd0);
        check("clr_ok_err",     32'(err),        32'd0);

        // Cross-direction sample: one error event, flag only when enabled
        step(6'b100100, 1'b0);
        check("conf_err_cnt", 32'(err_cnt), 32'd1);
        check("conf_err",     32'(err),     32'd1);
`ifdef TLM_CONFLICT_EN
        check("conf_flag", 32'(conflict), 32'd1);
`else
        check("conf_flag", 32'(conflict), 32'd0);
`endif

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #10;
        rst_n = 1'b1;
        step(PAT_NSG, 1'b0);
        check("post_rst_vld",   32'(phase_vld), 32'd1);
        check("post_rst_phase", 32'(phase),     32'd0);
        check("post_rst_lock",  32'(lock),      32'd0);
        check("post_rst_err",   32'(err),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
